// File: rtl/amber_timer_pkg.sv
// Shared register map, control-field layout and constants for the amber timer unit.
// Build option: define AMBER_TIMER_CASCADE_EN to let timers 1 and 2 count underflows of the previous timer.
package amber_timer_pkg;

   localparam int unsigned NUM_TIMERS = 3;
   localparam int unsigned CNT_W      = 16;
   localparam int unsigned CTRL_W     = 8;
   localparam int unsigned PRESCALE_W = 8;

   localparam logic [7:0] OFF_LOAD  = 8'h00;
   localparam logic [7:0] OFF_VALUE = 8'h04;
   localparam logic [7:0] OFF_CTRL  = 8'h08;
   localparam logic [7:0] OFF_CLEAR = 8'h0C;

   localparam int unsigned CTRL_EN_BIT       = 7;
   localparam int unsigned CTRL_PERIODIC_BIT = 6;
   localparam int unsigned CTRL_CASCADE_BIT  = 4;
   localparam int unsigned CTRL_PRESCALE_LSB = 2;

   typedef enum logic [1:0] {
      PRESCALE_DIV1       = 2'b00,
      PRESCALE_DIV16      = 2'b01,
      PRESCALE_DIV256     = 2'b10,
      PRESCALE_DIV256_ALT = 2'b11
   } prescale_e;

   typedef struct packed {
      logic      enable;
      logic      periodic;
      logic      rsvd5;
      logic      cascade;
      prescale_e prescale;
      logic [1:0] rsvd;
   } timer_ctrl_t;

`ifdef AMBER_TIMER_CASCADE_EN
   localparam bit CASCADE_EN = 1'b1;
`else
   localparam bit CASCADE_EN = 1'b0;
`endif

   // Writable CTRL bits; the cascade bit exists only where the channel may cascade.
   function automatic logic [CTRL_W-1:0] ctrl_mask(input bit cascade_ok);
      logic [CTRL_W-1:0] m;
      m = '0;
      m[CTRL_EN_BIT]           = 1'b1;
      m[CTRL_PERIODIC_BIT]     = 1'b1;
      m[CTRL_CASCADE_BIT]      = cascade_ok;
      m[CTRL_PRESCALE_LSB]     = 1'b1;
      m[CTRL_PRESCALE_LSB + 1] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/amber_timer_channel.sv
// One 16-bit down-counting timer: LOAD, VALUE, CTRL and a sticky interrupt flag.
// Cascade selection is only honoured when CASCADE_OK is set (see AMBER_TIMER_CASCADE_EN).
module amber_timer_channel
   import amber_timer_pkg::*;
#(
   parameter bit CASCADE_OK = 1'b0
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_div1,
   input  logic             tick_div16,
   input  logic             tick_div256,
   input  logic             cascade_tick,
   input  logic             load_we,
   input  logic             ctrl_we,
   input  logic             clear_we,
   input  logic [CNT_W-1:0] wdata,
   output logic [CNT_W-1:0] load,
   output logic [CNT_W-1:0] value,
   output timer_ctrl_t      ctrl,
   output logic             flag,
   output logic             underflow_c
);

   logic presc_tick;
   logic tick;
   logic count_c;

   // Pick this timer's tick source from the shared prescaler or the previous timer.
   always_comb begin
      presc_tick = tick_div256;
      case (ctrl.prescale)
         PRESCALE_DIV1:  presc_tick = tick_div1;
         PRESCALE_DIV16: presc_tick = tick_div16;
         default:        presc_tick = tick_div256;
      endcase
      tick = (CASCADE_OK && ctrl.cascade) ? cascade_tick : presc_tick;
   end

   // A LOAD write on the same edge swallows the tick.
   assign count_c     = ctrl.enable & tick & ~load_we;
   assign underflow_c = count_c & (value == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         load  <= '0;
         value <= '0;
         ctrl  <= '0;
         flag  <= 1'b0;
      end else begin
         if (load_we) begin
            load  <= wdata;
            value <= wdata;
         end else if (count_c) begin
            if (value == '0) begin
               value <= ctrl.periodic ? load : '1;
            end else begin
               value <= value - CNT_W'(1);
            end
         end

         if (ctrl_we) begin
            ctrl <= timer_ctrl_t'(wdata[CTRL_W-1:0] & ctrl_mask(CASCADE_OK));
         end

         // Underflow wins over a coincident clear.
         if (underflow_c) begin
            flag <= 1'b1;
         end else if (clear_we) begin
            flag <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/amber_timer_unit.sv
// Three-channel Wishbone timer block with shared prescaler and per-timer interrupt flags.
// Build option: AMBER_TIMER_CASCADE_EN enables cascading of timers 1 and 2.
module amber_timer_unit
   import amber_timer_pkg::*;
#(
   parameter int WB_DWIDTH = 32,
   parameter int WB_SWIDTH = 4
)
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [31:0]           i_wb_adr,
   input  logic [WB_SWIDTH-1:0]  i_wb_sel,
   input  logic                  i_wb_we,
   input  logic                  i_wb_cyc,
   input  logic                  i_wb_stb,
   input  logic [WB_DWIDTH-1:0]  i_wb_dat,
   output logic [WB_DWIDTH-1:0]  o_wb_dat,
   output logic                  o_wb_ack,
   output logic                  o_wb_err,
   output logic [NUM_TIMERS-1:0] o_timer_int
);

   localparam int unsigned LANES = WB_DWIDTH / 32;

   logic [PRESCALE_W-1:0] prescale_cnt;
   logic                  tick_div16;
   logic                  tick_div256;
   logic                  read_ack;
   logic [31:0]           read_data;
   logic [31:0]           read_mux;
   logic [31:0]           wdata32;
   logic                  write_en;
   logic                  read_start;
   logic [7:0]            adr_timer;
   logic [7:0]            adr_off;

   logic [NUM_TIMERS-1:0][CNT_W-1:0] load_v;
   logic [NUM_TIMERS-1:0][CNT_W-1:0] value_v;
   timer_ctrl_t                      ctrl_v [NUM_TIMERS];
   logic [NUM_TIMERS-1:0]            flag_v;

   logic unused;
   assign unused = ^{i_wb_sel, i_wb_cyc, i_wb_adr[31:16], wdata32[31:16]};

   assign adr_timer  = i_wb_adr[15:8];
   assign adr_off    = i_wb_adr[7:0];
   assign write_en   = i_wb_stb & i_wb_we & ~read_ack;
   assign read_start = i_wb_stb & ~i_wb_we & ~read_ack;

   assign o_wb_ack    = read_ack | (i_wb_stb & i_wb_we);
   assign o_wb_err    = 1'b0;
   assign o_wb_dat    = {LANES{read_data}};
   assign o_timer_int = flag_v;

   assign tick_div16  = (prescale_cnt[3:0] == 4'hF);
   assign tick_div256 = &prescale_cnt;

   // On a wide bus the write word comes from the lane addressed by adr[3:2].
   if (LANES > 1) begin : g_wide
      assign wdata32 = i_wb_dat[32*i_wb_adr[3:2] +: 32];
   end else begin : g_narrow
      assign wdata32 = i_wb_dat[31:0];
   end

   for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_ch
      logic hit;
      logic load_we;
      logic ctrl_we;
      logic clear_we;
      logic cascade_in;
      logic underflow;

      assign hit      = write_en && (adr_timer == 8'(n));
      assign load_we  = hit && (adr_off == OFF_LOAD);
      assign ctrl_we  = hit && (adr_off == OFF_CTRL);
      assign clear_we = hit && (adr_off == OFF_CLEAR);

      if (n == 0) begin : g_first
         assign cascade_in = 1'b0;
      end else begin : g_next
         assign cascade_in = g_ch[n-1].underflow;
      end

      if (n == NUM_TIMERS - 1) begin : g_last
         logic unused_tail;
         assign unused_tail = underflow;
      end

      amber_timer_channel #(
         .CASCADE_OK (CASCADE_EN && (n > 0))
      ) u_channel (
         .clk          (i_clk),
         .rst          (i_rst),
         .tick_div1    (1'b1),
         .tick_div16   (tick_div16),
         .tick_div256  (tick_div256),
         .cascade_tick (cascade_in),
         .load_we      (load_we),
         .ctrl_we      (ctrl_we),
         .clear_we     (clear_we),
         .wdata        (wdata32[CNT_W-1:0]),
         .load         (load_v[n]),
         .value        (value_v[n]),
         .ctrl         (ctrl_v[n]),
         .flag         (flag_v[n]),
         .underflow_c  (underflow)
      );
   end

   // Register read decode; unmapped and write-only locations read as zero.
   always_comb begin
      read_mux = '0;
      for (int n = 0; n < NUM_TIMERS; n++) begin
         if (adr_timer == 8'(n)) begin
            case (adr_off)
               OFF_LOAD:  read_mux = 32'(load_v[n]);
               OFF_VALUE: read_mux = 32'(value_v[n]);
               OFF_CTRL:  read_mux = 32'(ctrl_v[n]);
               default:   read_mux = '0;
            endcase
         end
      end
   end

   // Free-running prescaler plus the one-cycle read pipeline.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prescale_cnt <= '0;
         read_ack     <= 1'b0;
         read_data    <= '0;
      end else begin
         prescale_cnt <= prescale_cnt + PRESCALE_W'(1);
         read_ack     <= read_start;
         if (read_start) begin
            read_data <= read_mux;
         end
      end
   end

endmodule

// File: tb/tb_amber_timer_unit.sv
// Directed self-checking bench for amber_timer_unit: register vector table plus timing sequences.
module tb_amber_timer_unit;

   logic        clk;
   logic        rst;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic        stb;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        ack;
   logic        err;
   logic [2:0]  tint;

   int n_cmp;
   int n_err;

`ifdef AMBER_TIMER_CASCADE_EN
   localparam logic [31:0] CTRL1_EXP = 32'h0000_001C;
`else
   localparam logic [31:0] CTRL1_EXP = 32'h0000_000C;
`endif

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs [NV];

   amber_timer_unit #(
      .WB_DWIDTH (32),
      .WB_SWIDTH (4)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_wb_adr    (adr),
      .i_wb_sel    (sel),
      .i_wb_we     (we),
      .i_wb_cyc    (cyc),
      .i_wb_stb    (stb),
      .i_wb_dat    (dat_w),
      .o_wb_dat    (dat_r),
      .o_wb_ack    (ack),
      .o_wb_err    (err),
      .o_timer_int (tint)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Called at a negedge; commits on the following posedge and returns at the next negedge.
   task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
      adr = a; dat_w = d; we = 1'b1; stb = 1'b1; cyc = 1'b1;
      #1 check("write_ack", 32'(ack), 32'd1);
      @(negedge clk);
      stb = 1'b0; we = 1'b0; cyc = 1'b0;
   endtask

   // Read with one idle cycle afterwards so the ack has dropped before the next access.
   task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
      adr = a; we = 1'b0; stb = 1'b1; cyc = 1'b1;
      @(negedge clk);
      check("read_ack", 32'(ack), 32'd1);
      d = dat_r;
      stb = 1'b0; cyc = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1; adr = '0; sel = 4'hF; we = 1'b0; cyc = 1'b0; stb = 1'b0; dat_w = '0;

      vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,          32'h0};
      vecs[1]  = '{1'b0, 32'h0000_0104, 32'h0,          32'h0};
      vecs[2]  = '{1'b0, 32'h0000_0208, 32'h0,          32'h0};
      vecs[3]  = '{1'b1, 32'h0000_0000, 32'hABCD_1234,  32'h0};
      vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,          32'h0000_1234};
      vecs[5]  = '{1'b0, 32'h0000_0004, 32'h0,          32'h0000_1234};
      vecs[6]  = '{1'b1, 32'h0000_0100, 32'h0000_7777,  32'h0};
      vecs[7]  = '{1'b0, 32'h0000_0104, 32'h0,          32'h0000_7777};
      vecs[8]  = '{1'b1, 32'h0000_0208, 32'h0000_004C,  32'h0};
      vecs[9]  = '{1'b0, 32'h0000_0208, 32'h0,          32'h0000_004C};
      vecs[10] = '{1'b1, 32'h0000_0108, 32'h0000_003F,  32'h0};
      vecs[11] = '{1'b0, 32'h0000_0108, 32'h0,          CTRL1_EXP};
      vecs[12] = '{1'b1, 32'h0000_0008, 32'h0000_003F,  32'h0};
      vecs[13] = '{1'b0, 32'h0000_0008, 32'h0,          32'h0000_000C};
      vecs[14] = '{1'b0, 32'h0000_000C, 32'h0,          32'h0};
      vecs[15] = '{1'b0, 32'h0000_0300, 32'h0,          32'h0};
      vecs[16] = '{1'b0, 32'h0000_0010, 32'h0,          32'h0};
      vecs[17] = '{1'b0, 32'h0000_0002, 32'h0,          32'h0};
      vecs[18] = '{1'b1, 32'h0000_0304, 32'h0000_FFFF,  32'h0};
      vecs[19] = '{1'b0, 32'h1234_0000, 32'h0,          32'h0000_1234};
      vecs[20] = '{1'b1, 32'h0000_0004, 32'h0000_5555,  32'h0};
      vecs[21] = '{1'b0, 32'h0000_0004, 32'h0,          32'h0000_1234};
      vecs[22] = '{1'b1, 32'h0000_0200, 32'h0000_FFFF,  32'h0};
      vecs[23] = '{1'b0, 32'h0000_0204, 32'h0,          32'h0000_FFFF};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_int", 32'(tint), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rdat", dat_r, 32'd0);
      rst = 1'b0;

      // Register map vectors
      for (int i = 0; i < NV; i++) begin
         if (vecs[i].we) begin
            wb_write(vecs[i].adr, vecs[i].dat);
         end else begin
            wb_read(vecs[i].adr, rd);
            check($sformatf("vec%0d_rdat", i), rd, vecs[i].exp);
         end
      end

      // Periodic timer0, LOAD=5, divide-by-1
      wb_write(32'h0000_0000, 32'd5);
      wb_write(32'h0000_0008, 32'h0000_00C0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k >= 5) check($sformatf("t0_int_k%0d", k), 32'(tint[0]), (k >= 6) ? 32'd1 : 32'd0);
      end
      wb_read(32'h0000_0004, rd);
      check("t0_reload", rd, 32'd5);
      wb_write(32'h0000_0008, 32'h0);
      check("t0_int_held", 32'(tint[0]), 32'd1);
      wb_write(32'h0000_000C, 32'h0);
      check("t0_int_cleared", 32'(tint[0]), 32'd0);
      wb_read(32'h0000_0004, rd);
      check("t0_hold", rd, 32'd2);

      // One-shot timer1 at divide-by-16 from a freshly reset prescaler
      pulse_reset();
      wb_write(32'h0000_0100, 32'd2);
      wb_write(32'h0000_0108, 32'h0000_0084);
      for (int k = 3; k <= 48; k++) begin
         @(negedge clk);
         if (k >= 47) check($sformatf("t1_int_k%0d", k), 32'(tint[1]), (k >= 48) ? 32'd1 : 32'd0);
      end
      wb_read(32'h0000_0104, rd);
      check("t1_wrap", rd, 32'h0000_FFFF);

      // Reset while timer0 counts at VALUE=3, with a read pending and a write attempted
      wb_write(32'h0000_0000, 32'd10);
      wb_write(32'h0000_0008, 32'h0000_0080);
      repeat (7) @(negedge clk);
      check("pre_rst_int", 32'(tint), 32'b010);
      rst = 1'b1; adr = 32'h0000_0004; we = 1'b0; stb = 1'b1; cyc = 1'b1;
      @(negedge clk);
      check("rst_read_cancel", 32'(ack), 32'd0);
      check("rst_int_clear", 32'(tint), 32'd0);
      adr = 32'h0000_0000; dat_w = 32'h55; we = 1'b1;
      #1 check("rst_write_ack", 32'(ack), 32'd1);
      @(negedge clk);
      rst = 1'b0; stb = 1'b0; we = 1'b0; cyc = 1'b0;
      wb_read(32'h0000_0000, rd); check("rst_load0", rd, 32'd0);
      wb_read(32'h0000_0004, rd); check("rst_value0", rd, 32'd0);
      wb_read(32'h0000_0008, rd); check("rst_ctrl0", rd, 32'd0);
      wb_read(32'h0000_0100, rd); check("rst_load1", rd, 32'd0);
      wb_read(32'h0000_0104, rd); check("rst_value1", rd, 32'd0);
      wb_read(32'h0000_0108, rd); check("rst_ctrl1", rd, 32'd0);

      // Read with strobe held for three cycles
      wb_write(32'h0000_0000, 32'h0000_1234);
      adr = 32'h0000_0004; we = 1'b0; stb = 1'b1; cyc = 1'b1;
      #1 check("hold_ack_c0", 32'(ack), 32'd0);
      @(negedge clk);
      check("hold_ack_c1", 32'(ack), 32'd1);
      check("hold_rdat", dat_r, 32'h0000_1234);
      @(negedge clk);
      check("hold_ack_c2", 32'(ack), 32'd0);
      @(negedge clk);
      check("hold_ack_c3", 32'(ack), 32'd1);
      stb = 1'b0; cyc = 1'b0;
      @(negedge clk);
      check("hold_ack_c4", 32'(ack), 32'd0);

      // CLEAR coinciding with an underflow on timer2, then a clean CLEAR
      wb_write(32'h0000_0200, 32'd1);
      wb_write(32'h0000_0208, 32'h0000_00C0);
      @(negedge clk);
      wb_write(32'h0000_020C, 32'h0);
      check("t2_clear_vs_set", 32'(tint[2]), 32'd1);
      wb_write(32'h0000_020C, 32'h0);
      check("t2_clear", 32'(tint[2]), 32'd0);
      wb_write(32'h0000_0208, 32'h0);
      check("t2_set_again", 32'(tint[2]), 32'd1);
      wb_write(32'h0000_020C, 32'h0);
      check("t2_clear_disabled", 32'(tint[2]), 32'd0);

`ifdef AMBER_TIMER_CASCADE_EN
      // Timer1 cascaded on timer0 underflows
      pulse_reset();
      wb_write(32'h0000_0100, 32'd1);
      wb_write(32'h0000_0108, 32'h0000_0090);
      wb_write(32'h0000_0000, 32'd1);
      wb_write(32'h0000_0008, 32'h0000_00C0);
      for (int k = 4; k <= 7; k++) begin
         @(negedge clk);
         check($sformatf("casc_int1_k%0d", k), 32'(tint[1]), (k >= 7) ? 32'd1 : 32'd0);
         if (k == 5) check("casc_int0", 32'(tint[0]), 32'd1);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/amber_timer_unit.md
AMBER_TIMER_UNIT -- requirements
Module: amber_timer_unit

Interface
REQ-001 The block SHALL have parameter WB_DWIDTH, default 32, giving the Wishbone data width (32 or 128).
REQ-002 The block SHALL have parameter WB_SWIDTH, default 4, giving the Wishbone byte-select width.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i_wb_adr, input, 32 bits: Wishbone address; bits [15:0] are decoded.
REQ-006 The block SHALL have port i_wb_sel, input, WB_SWIDTH bits: byte selects; ignored, full-word access only.
REQ-007 The block SHALL have ports i_wb_we, i_wb_cyc and i_wb_stb, each input, 1 bit: Wishbone write enable, cycle and strobe.
REQ-008 The block SHALL have ports i_wb_dat (input) and o_wb_dat (output), each WB_DWIDTH bits: write and read data.
REQ-009 The block SHALL have ports o_wb_ack and o_wb_err, each output, 1 bit; o_wb_err is tied to 0.
REQ-010 The block SHALL have port o_timer_int, output, 3 bits: per-timer interrupt flags, wired to the interrupt controller's i_tm_timer_int.

Function
REQ-011 The block SHALL contain 3 independent 16-bit down-counting timers; timer n register base = n*0x100.
REQ-012 Register map per timer: LOAD 0x00 (R/W, [15:0]); VALUE 0x04 (RO, [15:0]); CTRL 0x08 (R/W: bit7 enable, bit6 periodic, bits[3:2] prescale, bit4 cascade, see REQ-027); CLEAR 0x0C (WO, any data clears that timer's interrupt).
REQ-013 Unmapped reads SHALL return 32'h0; unmapped writes SHALL have no effect.
REQ-014 A write SHALL be acked combinationally: o_wb_ack = stb & we, unless a read ack is pending in that cycle.
REQ-015 A read SHALL capture data at the first stb cycle and ack exactly one cycle later; no new read starts while o_wb_ack is high.
REQ-016 For WB_DWIDTH=128, write data SHALL be taken from the lane selected by i_wb_adr[3:2]; read data SHALL be replicated 4 times.
REQ-017 A shared 8-bit free-running prescale counter SHALL generate ticks: prescale 00 = every cycle, 01 = when count[3:0]==4'hF, 10 = when count==8'hFF; 11 behaves as 10.
REQ-018 An enabled timer SHALL decrement VALUE by 1 on each tick of its prescale.
REQ-019 On a tick with VALUE==0, the timer SHALL set its interrupt flag. If periodic=1, VALUE SHALL reload from LOAD; otherwise VALUE SHALL wrap to 16'hFFFF.
REQ-020 A write to LOAD SHALL update LOAD and VALUE in the same edge; a simultaneous tick on that edge is discarded.
REQ-021 The interrupt flag SHALL be sticky until a CLEAR write or reset; if CLEAR and an underflow coincide, set SHALL win.
REQ-022 A disabled timer SHALL hold VALUE, and its flag SHALL hold its current state.
REQ-023 o_timer_int[n] SHALL be the registered flag of timer n; flag rise SHALL be visible one cycle after the underflow tick edge.

Reset
REQ-024 On i_rst: LOAD, VALUE, CTRL, flags, prescale counter, read-data register and read-pending SHALL all be 0; o_timer_int SHALL be 3'b000.
REQ-025 Reset asserted mid-read SHALL cancel the pending ack; o_wb_ack SHALL still reflect the combinational write term.
REQ-026 Reset SHALL take priority over all register writes and ticks in the same cycle.

Configuration
REQ-027 With macro AMBER_TIMER_CASCADE_EN defined, CTRL bit4 on timers 1 and 2 SHALL be writable; when set, that timer SHALL tick on timer n-1 underflow instead of on the prescaler. Without the macro, bit4 SHALL read 0 and be ignored.

Structure
REQ-028 Package amber_timer_pkg SHALL hold the register offsets, CTRL bit positions, prescale encodings and the timer count (3).
REQ-029 Sub-module amber_timer_channel (LOAD/VALUE/CTRL/flag for one timer, inputs tick/write strobes) SHALL be instantiated 3 times.

Verification
REQ-030 LOAD0=5, CTRL0=0xC0 (enable, periodic, /1) -> o_timer_int[0] rises 6 cycles after the CTRL write, then VALUE0 reloads to 5.
REQ-031 LOAD1=2, CTRL1=0x84 (one-shot, /16), prescaler at 0 -> flag rises after the 3rd /16 tick; VALUE1 reads 0xFFFF.
REQ-032 Flag set on timer2, CLEAR write coincident with a new underflow -> flag stays 1; a CLEAR on the next cycle clears it.
REQ-033 Read VALUE0 with stb held 3 cycles -> ack high exactly one cycle after stb; no second capture until ack falls.
REQ-034 i_rst pulsed while timer0 is counting at VALUE=3 -> all registers read 0 and o_timer_int=0 on the next cycle.
REQ-035 (AMBER_TIMER_CASCADE_EN) Timer0 periodic LOAD=1, timer1 cascade with LOAD=1 -> timer1 flag rises on the 2nd timer0 underflow.
